delivery_scheduler: RTL and testbench
=====================================

# delivery_scheduler

Sequences mail drop-off for the rover. Consumes per-window beacon frequency measurements from the IR frequency counter, confirms which of three mailbox beacons is in view, halts the drive, and hands one delivery job at a time to the arm state machine via a start/done handshake. Tracks which mailboxes have been served and asserts a final stop once all three are done.

## Interface
Parameters:
- BIN0_LO, 900: mailbox 0 lower bound, exclusive.
- BIN0_HI, 1500: mailbox 0 upper bound, inclusive.
- BIN1_LO, 95 / BIN1_HI, 105: mailbox 1 bounds, same rule.
- BIN2_LO, 7 / BIN2_HI, 12: mailbox 2 bounds, same rule.
- CONFIRM, 2: consecutive matching windows required to accept a target; range 1..15.
- HOLDOFF, 25_000_000: cycles that detections are ignored after a job.
- TIMEOUT, 500_000_000: arm job watchdog in cycles; used only with ARM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- clr_n  in  1  reset; asynchronous, active-low.
- freq_valid  in  1  one-cycle strobe: new measurement on freq_count.
- freq_count  in  32  scaled edge count for the finished gate window.
- arm_done  in  1  one-cycle strobe from the arm: job complete.
- arm_start  out  1  one-cycle job launch strobe.
- arm_sel  out  2  mailbox index of the current job (0..2).
- drive_stop  out  1  halts the wheel drive.
- delivered  out  3  sticky per-mailbox served mask.
- all_done  out  1  all three mailboxes served.
- target_led  out  3  one-hot of the mailbox being confirmed or served.
- fault  out  1  sticky arm timeout flag (tied 0 without ARM_TIMEOUT_EN).

## Operation
- Classify: freq_count maps to bin k when BINk_LO < freq_count <= BINk_HI; first match in order 0,1,2 wins; a bin whose delivered bit is set counts as no match.
- States: SEARCH, DISPATCH, BUSY, HOLDOFF, DONE.
- SEARCH: on each freq_valid: match equal to the held candidate -> conf_cnt+1; match to a different bin -> candidate = new bin, conf_cnt = 1; no match -> conf_cnt = 0, target_led = 0. When conf_cnt reaches CONFIRM -> DISPATCH, arm_sel = candidate. freq_valid outside SEARCH is ignored.
- DISPATCH: one cycle; arm_start = 1; -> BUSY.
- BUSY: drive_stop = 1, arm_sel held; arm_done -> set delivered[arm_sel], -> HOLDOFF.
- HOLDOFF: drive_stop = 0; count HOLDOFF cycles; then -> DONE if delivered == 3'b111, else SEARCH with conf_cnt = 0.
- DONE: drive_stop = 1, all_done = 1, target_led = 0; terminal until reset.
- arm_done outside BUSY is ignored.

## Timing
- Reset values: arm_start 0, arm_sel 0, drive_stop 0, delivered 0, all_done 0, target_led 0, fault 0, state SEARCH, conf_cnt 0, counters 0.
- All outputs registered.
- The freq_valid that completes confirmation puts the block in DISPATCH on the next edge; arm_start is high exactly that cycle; drive_stop rises together with arm_start and stays high through BUSY.
- arm_done in BUSY: delivered updates and drive_stop falls on the next edge.
- HOLDOFF lasts exactly HOLDOFF cycles; the following edge enters SEARCH or DONE.
- arm_done coincident with DISPATCH: ignored; the job waits for a later arm_done.
- clr_n low mid-job: every output clears immediately; no pending job survives.
- conf_cnt saturates at 15.

## Configuration
- ARM_TIMEOUT_EN defined: BUSY counts cycles. On reaching TIMEOUT without arm_done: fault set (sticky), delivered unchanged, -> HOLDOFF; the mailbox can be retried later. arm_done on the same edge as the timeout wins: normal completion, no fault.
- Undefined: no watchdog; BUSY waits indefinitely; fault constant 0.

## Test plan
Bench uses HOLDOFF=20, TIMEOUT=100, CONFIRM=2.
- freq_count 1000 on two strobes -> arm_start one cycle later, arm_sel 0, target_led 001, drive_stop 1; arm_done -> delivered 001, drive_stop 0 next edge.
- Strobes 100, 10, 10 -> candidate switches; dispatch on the third strobe with arm_sel 2; no dispatch for bin 1.
- After mailbox 0 is served, two strobes of 1200 -> no dispatch; boundary values 900 and 105 -> 900 ignored, 105 accepted as bin 1.
- Serve bins 0, 1, 2 in sequence -> after the final HOLDOFF: all_done 1, drive_stop 1; further strobes and arm_done have no effect.
- ARM_TIMEOUT_EN, no arm_done for 100 cycles -> fault 1, delivered unchanged, HOLDOFF then SEARCH; retry succeeds with fault still 1.
- clr_n low while in BUSY -> all outputs 0 immediately; after release, a fresh CONFIRM is required before dispatch.

Source files
------------

// File: rtl/delivery_scheduler.sv
// Mail drop-off sequencer: confirms a mailbox beacon from frequency windows, halts the drive
// and hands one arm job at a time. Optional arm watchdog enabled by defining ARM_TIMEOUT_EN.
module delivery_scheduler #(
  parameter int unsigned BIN0_LO = 900,
  parameter int unsigned BIN0_HI = 1500,
  parameter int unsigned BIN1_LO = 95,
  parameter int unsigned BIN1_HI = 105,
  parameter int unsigned BIN2_LO = 7,
  parameter int unsigned BIN2_HI = 12,
  parameter int unsigned CONFIRM = 2,
  parameter int unsigned HOLDOFF = 25_000_000,
  parameter int unsigned TIMEOUT = 500_000_000
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        freq_valid,
  input  logic [31:0] freq_count,
  input  logic        arm_done,
  output logic        arm_start,
  output logic [1:0]  arm_sel,
  output logic        drive_stop,
  output logic [2:0]  delivered,
  output logic        all_done,
  output logic [2:0]  target_led,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_SEARCH   = 3'd0,
    S_DISPATCH = 3'd1,
    S_BUSY     = 3'd2,
    S_HOLDOFF  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [3:0] CONF_TGT = 4'(CONFIRM);

  state_t      state_q, state_d;
  logic [1:0]  cand_q, cand_d;
  logic [3:0]  conf_cnt_q, conf_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic        arm_start_q, arm_start_d;
  logic [1:0]  arm_sel_q, arm_sel_d;
  logic        drive_stop_q, drive_stop_d;
  logic [2:0]  delivered_q, delivered_d;
  logic        all_done_q, all_done_d;
  logic [2:0]  target_led_q, target_led_d;

  // A served mailbox is masked out so its beacon can no longer be matched.
  logic [2:0] hit;
  logic       match_any;
  logic [1:0] match_idx;
  logic [3:0] conf_next;

  always_comb begin
    hit[0] = (freq_count > BIN0_LO) && (freq_count <= BIN0_HI) && !delivered_q[0];
    hit[1] = (freq_count > BIN1_LO) && (freq_count <= BIN1_HI) && !delivered_q[1];
    hit[2] = (freq_count > BIN2_LO) && (freq_count <= BIN2_HI) && !delivered_q[2];
    match_any = |hit;
    match_idx = hit[0] ? 2'd0 : (hit[1] ? 2'd1 : 2'd2);
    if (match_idx != cand_q)       conf_next = 4'd1;
    else if (conf_cnt_q == 4'd15)  conf_next = 4'd15;
    else                           conf_next = conf_cnt_q + 4'd1;
  end

`ifdef ARM_TIMEOUT_EN
  logic [31:0] busy_cnt_q, busy_cnt_d;
  logic        fault_q, fault_d;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    conf_cnt_d   = conf_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    arm_start_d  = 1'b0;
    arm_sel_d    = arm_sel_q;
    drive_stop_d = drive_stop_q;
    delivered_d  = delivered_q;
    all_done_d   = all_done_q;
    target_led_d = target_led_q;
`ifdef ARM_TIMEOUT_EN
    busy_cnt_d   = busy_cnt_q;
    fault_d      = fault_q;
`endif
    case (state_q)
      S_SEARCH: begin
        if (freq_valid) begin
          if (match_any) begin
            cand_d       = match_idx;
            conf_cnt_d   = conf_next;
            target_led_d = 3'b001 << match_idx;
            if (conf_next >= CONF_TGT) begin
              state_d      = S_DISPATCH;
              arm_sel_d    = match_idx;
              arm_start_d  = 1'b1;
              drive_stop_d = 1'b1;
            end
          end else begin
            conf_cnt_d   = 4'd0;
            target_led_d = 3'b000;
          end
        end
      end
      S_DISPATCH: begin
        state_d = S_BUSY;
`ifdef ARM_TIMEOUT_EN
        busy_cnt_d = 32'd0;
`endif
      end
      S_BUSY: begin
        // A completion on the timeout edge wins over the watchdog.
        if (arm_done) begin
          delivered_d  = delivered_q | (3'b001 << arm_sel_q);
          drive_stop_d = 1'b0;
          target_led_d = 3'b000;
          hold_cnt_d   = 32'd0;
          state_d      = S_HOLDOFF;
        end
`ifdef ARM_TIMEOUT_EN
        else if (busy_cnt_q == TIMEOUT - 1) begin
          fault_d      = 1'b1;
          drive_stop_d = 1'b0;
          target_led_d = 3'b000;
          hold_cnt_d   = 32'd0;
          state_d      = S_HOLDOFF;
        end else begin
          busy_cnt_d = busy_cnt_q + 32'd1;
        end
`endif
      end
      S_HOLDOFF: begin
        if (hold_cnt_q == HOLDOFF - 1) begin
          if (delivered_q == 3'b111) begin
            state_d      = S_DONE;
            drive_stop_d = 1'b1;
            all_done_d   = 1'b1;
            target_led_d = 3'b000;
          end else begin
            state_d    = S_SEARCH;
            conf_cnt_d = 4'd0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= S_SEARCH;
      cand_q       <= 2'd0;
      conf_cnt_q   <= 4'd0;
      hold_cnt_q   <= 32'd0;
      arm_start_q  <= 1'b0;
      arm_sel_q    <= 2'd0;
      drive_stop_q <= 1'b0;
      delivered_q  <= 3'b000;
      all_done_q   <= 1'b0;
      target_led_q <= 3'b000;
`ifdef ARM_TIMEOUT_EN
      busy_cnt_q   <= 32'd0;
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      conf_cnt_q   <= conf_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      arm_start_q  <= arm_start_d;
      arm_sel_q    <= arm_sel_d;
      drive_stop_q <= drive_stop_d;
      delivered_q  <= delivered_d;
      all_done_q   <= all_done_d;
      target_led_q <= target_led_d;
`ifdef ARM_TIMEOUT_EN
      busy_cnt_q   <= busy_cnt_d;
      fault_q      <= fault_d;
`endif
    end
  end

  assign arm_start  = arm_start_q;
  assign arm_sel    = arm_sel_q;
  assign drive_stop = drive_stop_q;
  assign delivered  = delivered_q;
  assign all_done   = all_done_q;
  assign target_led = target_led_q;

endmodule

// File: tb/tb_delivery_scheduler.sv
// Bench for delivery_scheduler: dispatches are scoreboarded against an expected arm_sel queue,
// each scenario task checks its own outputs inline. Watchdog scenario follows ARM_TIMEOUT_EN.
module tb_delivery_scheduler;
  localparam int HOLD = 20;
  localparam int TMO  = 100;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        freq_valid = 1'b0;
  logic [31:0] freq_count = 32'd0;
  logic        arm_done = 1'b0;
  logic        arm_start;
  logic [1:0]  arm_sel;
  logic        drive_stop;
  logic [2:0]  delivered;
  logic        all_done;
  logic [2:0]  target_led;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_sel;

  delivery_scheduler #(.CONFIRM(2), .HOLDOFF(HOLD), .TIMEOUT(TMO)) dut (
    .clk(clk), .clr_n(clr_n), .freq_valid(freq_valid), .freq_count(freq_count),
    .arm_done(arm_done), .arm_start(arm_start), .arm_sel(arm_sel), .drive_stop(drive_stop),
    .delivered(delivered), .all_done(all_done), .target_led(target_led), .fault(fault)
  );

  always #5 clk = ~clk;

  // Scoreboard: every arm_start must match the next expected mailbox.
  always @(negedge clk) begin
    if (clr_n && arm_start) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_dispatch: arm_sel=%0d, required no dispatch", arm_sel);
      end else begin
        exp_sel = exp_q.pop_front();
        if (arm_sel !== exp_sel) begin
          n_err++;
          $display("FAIL dispatch_sel: arm_sel=%0d, required %0d", arm_sel, exp_sel);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "bench time limit reached");
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic strobe(input logic [31:0] f);
    @(negedge clk);
    freq_valid = 1'b1;
    freq_count = f;
    @(negedge clk);
    freq_valid = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    arm_done = 1'b1;
    @(negedge clk);
    arm_done = 1'b0;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    wait_cycles(3);
    n_cmp++;
    if ({arm_start, arm_sel, drive_stop, delivered, all_done, target_led, fault} !== 12'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {arm_start, arm_sel, drive_stop, delivered, all_done, target_led, fault});
    end
    clr_n = 1'b1;
  endtask

  task automatic test_dispatch_bin0();
    strobe(1000);
    n_cmp++;
    if (target_led !== 3'b001 || arm_start !== 1'b0) begin
      n_err++;
      $display("FAIL t1_first_strobe: led=%b start=%b, required led=001 start=0", target_led, arm_start);
    end
    exp_q.push_back(2'd0);
    strobe(1000);
    n_cmp++;
    if (arm_start !== 1'b1 || arm_sel !== 2'd0 || drive_stop !== 1'b1 || target_led !== 3'b001) begin
      n_err++;
      $display("FAIL t1_dispatch: start=%b sel=%0d stop=%b led=%b, required 1 0 1 001",
               arm_start, arm_sel, drive_stop, target_led);
    end
    @(negedge clk);
    n_cmp++;
    if (arm_start !== 1'b0 || drive_stop !== 1'b1) begin
      n_err++;
      $display("FAIL t1_busy: start=%b stop=%b, required start=0 stop=1", arm_start, drive_stop);
    end
    pulse_done();
    n_cmp++;
    if (delivered !== 3'b001 || drive_stop !== 1'b0) begin
      n_err++;
      $display("FAIL t1_done: delivered=%b stop=%b, required 001 0", delivered, drive_stop);
    end
    // Strobes during the hold-off window must not start a job.
    strobe(10);
    strobe(10);
    wait_cycles(HOLD);
  endtask

  task automatic test_candidate_switch();
    strobe(100);
    n_cmp++;
    if (target_led !== 3'b010) begin
      n_err++;
      $display("FAIL t2_led_bin1: led=%b, required 010", target_led);
    end
    strobe(10);
    n_cmp++;
    if (target_led !== 3'b100 || arm_start !== 1'b0) begin
      n_err++;
      $display("FAIL t2_switch: led=%b start=%b, required 100 0", target_led, arm_start);
    end
    exp_q.push_back(2'd2);
    strobe(10);
    n_cmp++;
    if (arm_start !== 1'b1 || arm_sel !== 2'd2 || target_led !== 3'b100) begin
      n_err++;
      $display("FAIL t2_dispatch: start=%b sel=%0d led=%b, required 1 2 100", arm_start, arm_sel, target_led);
    end
    pulse_done();
    n_cmp++;
    if (delivered !== 3'b101) begin
      n_err++;
      $display("FAIL t2_delivered: delivered=%b, required 101", delivered);
    end
    wait_cycles(HOLD + 2);
  endtask

  task automatic test_served_and_boundary();
    strobe(1200);
    strobe(1200);
    n_cmp++;
    if (target_led !== 3'b000 || arm_start !== 1'b0 || drive_stop !== 1'b0) begin
      n_err++;
      $display("FAIL t3_served_bin0: led=%b start=%b stop=%b, required 000 0 0", target_led, arm_start, drive_stop);
    end
    strobe(900);
    n_cmp++;
    if (target_led !== 3'b000) begin
      n_err++;
      $display("FAIL t3_edge_900: led=%b, required 000", target_led);
    end
    strobe(105);
    n_cmp++;
    if (target_led !== 3'b010) begin
      n_err++;
      $display("FAIL t3_edge_105: led=%b, required 010", target_led);
    end
    exp_q.push_back(2'd1);
    strobe(105);
    n_cmp++;
    if (arm_start !== 1'b1 || arm_sel !== 2'd1) begin
      n_err++;
      $display("FAIL t3_dispatch: start=%b sel=%0d, required 1 1", arm_start, arm_sel);
    end
  endtask

  task automatic test_all_done();
    pulse_done();
    n_cmp++;
    if (delivered !== 3'b111 || drive_stop !== 1'b0 || all_done !== 1'b0) begin
      n_err++;
      $display("FAIL t4_last_done: delivered=%b stop=%b all=%b, required 111 0 0", delivered, drive_stop, all_done);
    end
    wait_cycles(HOLD - 1);
    n_cmp++;
    if (all_done !== 1'b0 || drive_stop !== 1'b0) begin
      n_err++;
      $display("FAIL t4_holdoff_end: all=%b stop=%b, required 0 0", all_done, drive_stop);
    end
    wait_cycles(1);
    n_cmp++;
    if (all_done !== 1'b1 || drive_stop !== 1'b1 || target_led !== 3'b000) begin
      n_err++;
      $display("FAIL t4_done_state: all=%b stop=%b led=%b, required 1 1 000", all_done, drive_stop, target_led);
    end
    strobe(1000);
    strobe(1000);
    strobe(100);
    strobe(100);
    pulse_done();
    n_cmp++;
    if (delivered !== 3'b111 || all_done !== 1'b1 || drive_stop !== 1'b1 || target_led !== 3'b000) begin
      n_err++;
      $display("FAIL t4_terminal: delivered=%b all=%b stop=%b led=%b, required 111 1 1 000",
               delivered, all_done, drive_stop, target_led);
    end
  endtask

  task automatic test_coincident_done();
    @(negedge clk);
    clr_n = 1'b0;
    wait_cycles(2);
    clr_n = 1'b1;
    strobe(900);
    strobe(900);
    strobe(1501);
    n_cmp++;
    if (target_led !== 3'b000 || drive_stop !== 1'b0) begin
      n_err++;
      $display("FAIL t5_out_of_band: led=%b stop=%b, required 000 0", target_led, drive_stop);
    end
    strobe(1500);
    exp_q.push_back(2'd0);
    strobe(1500);
    n_cmp++;
    if (arm_start !== 1'b1 || arm_sel !== 2'd0) begin
      n_err++;
      $display("FAIL t5_dispatch_1500: start=%b sel=%0d, required 1 0", arm_start, arm_sel);
    end
    arm_done = 1'b1;
    @(negedge clk);
    arm_done = 1'b0;
    n_cmp++;
    if (delivered !== 3'b000 || drive_stop !== 1'b1) begin
      n_err++;
      $display("FAIL t5_done_in_dispatch: delivered=%b stop=%b, required 000 1", delivered, drive_stop);
    end
  endtask

  task automatic test_watchdog();
`ifdef ARM_TIMEOUT_EN
    wait_cycles(TMO - 4);
    n_cmp++;
    if (fault !== 1'b0 || drive_stop !== 1'b1) begin
      n_err++;
      $display("FAIL t6_before_timeout: fault=%b stop=%b, required 0 1", fault, drive_stop);
    end
    wait_cycles(4);
    n_cmp++;
    if (fault !== 1'b1 || delivered !== 3'b000 || drive_stop !== 1'b0) begin
      n_err++;
      $display("FAIL t6_timeout: fault=%b delivered=%b stop=%b, required 1 000 0", fault, delivered, drive_stop);
    end
    wait_cycles(HOLD + 2);
    strobe(1000);
    exp_q.push_back(2'd0);
    strobe(1000);
    n_cmp++;
    if (arm_start !== 1'b1 || arm_sel !== 2'd0) begin
      n_err++;
      $display("FAIL t6_retry_dispatch: start=%b sel=%0d, required 1 0", arm_start, arm_sel);
    end
    pulse_done();
    n_cmp++;
    if (delivered !== 3'b001 || fault !== 1'b1) begin
      n_err++;
      $display("FAIL t6_retry_done: delivered=%b fault=%b, required 001 1", delivered, fault);
    end
`else
    wait_cycles(TMO + 50);
    n_cmp++;
    if (fault !== 1'b0 || drive_stop !== 1'b1 || delivered !== 3'b000) begin
      n_err++;
      $display("FAIL t6_no_watchdog: fault=%b stop=%b delivered=%b, required 0 1 000", fault, drive_stop, delivered);
    end
    pulse_done();
    n_cmp++;
    if (delivered !== 3'b001 || drive_stop !== 1'b0) begin
      n_err++;
      $display("FAIL t6_late_done: delivered=%b stop=%b, required 001 0", delivered, drive_stop);
    end
`endif
    wait_cycles(HOLD + 2);
  endtask

  task automatic test_reset_mid_job();
    strobe(100);
    exp_q.push_back(2'd1);
    strobe(100);
    n_cmp++;
    if (arm_start !== 1'b1 || arm_sel !== 2'd1) begin
      n_err++;
      $display("FAIL t7_dispatch: start=%b sel=%0d, required 1 1", arm_start, arm_sel);
    end
    wait_cycles(4);
    clr_n = 1'b0;
    #1;
    n_cmp++;
    if ({arm_start, arm_sel, drive_stop, delivered, all_done, target_led, fault} !== 12'd0) begin
      n_err++;
      $display("FAIL t7_async_clear: got %b, required all zero",
               {arm_start, arm_sel, drive_stop, delivered, all_done, target_led, fault});
    end
    wait_cycles(2);
    clr_n = 1'b1;
    strobe(100);
    n_cmp++;
    if (arm_start !== 1'b0 || target_led !== 3'b010 || drive_stop !== 1'b0) begin
      n_err++;
      $display("FAIL t7_reconfirm: start=%b led=%b stop=%b, required 0 010 0", arm_start, target_led, drive_stop);
    end
    exp_q.push_back(2'd1);
    strobe(100);
    n_cmp++;
    if (arm_start !== 1'b1 || arm_sel !== 2'd1) begin
      n_err++;
      $display("FAIL t7_redispatch: start=%b sel=%0d, required 1 1", arm_start, arm_sel);
    end
    pulse_done();
    n_cmp++;
    if (delivered !== 3'b010) begin
      n_err++;
      $display("FAIL t7_delivered: delivered=%b, required 010", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_dispatch_bin0();
    test_candidate_switch();
    test_served_and_boundary();
    test_all_done();
    test_coincident_done();
    test_watchdog();
    test_reset_mid_job();
    wait_cycles(2);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_dispatch: %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
